program_loader: RTL and testbench
=================================

// Module: program_loader
// PURPOSE
// - Debug-side controller that loads a MIPS program from the UART receiver into instruction memory.
// - Holds the core in reset while loading; assembles 8-bit UART bytes into LEN-bit words, MSB first.
// - Issues one write strobe per word and stops on a HALT word, capacity overflow or an inter-byte timeout.
// - Sits between the UART rx side and the instruction-memory write port; debug FSM pulses `start` on reprogram.
// PARAMETERS
// - LEN                 32            instruction width (multiple of LEN_DATA)
// - LEN_DATA            8             UART byte width
// - CANT_INSTRUCCIONES  64            instruction memory depth, in words
// - NB_ADDR             $clog2(CANT_INSTRUCCIONES)   address width
// - HALT_WORD           32'hFFFFFFFF  end-of-program word (this word is also written)
// - TIMEOUT_CYCLES      1000000       max clk cycles between bytes while loading
// PORTS
// - clk           in   1         system clock
// - reset         in   1         asynchronous, active-low reset
// - start         in   1         1-cycle load request
// - rx_done       in   1         1-cycle pulse: uart_data_in valid
// - uart_data_in  in   LEN_DATA  received byte
// - mem_wr_en     out  1         instruction-memory write strobe (1 cycle per word)
// - mem_addr      out  NB_ADDR   write address
// - mem_wr_data   out  LEN       write data
// - hold_mips     out  1         reset request to the MIPS core
// - busy          out  1         load in progress
// - done          out  1         level: last load completed OK
// - error         out  1         level: last load aborted
// - word_count    out  NB_ADDR+1 words written in the current/last load
// BEHAVIOUR
// - Reset (reset=0, async): state IDLE; all outputs 0; counters cleared; memory contents untouched.
// - States: IDLE, WAIT_BYTE, WRITE, CHECK (macro only), DONE, ERROR.
// - Outputs: busy=1 in WAIT_BYTE/WRITE/CHECK; hold_mips=1 in WAIT_BYTE/WRITE/CHECK/ERROR, 0 in IDLE/DONE.
// - start in IDLE/DONE/ERROR -> WAIT_BYTE next cycle: addr=0, byte_idx=0, word_count=0, done=0, error=0, timer=0.
//   start while busy is ignored.
// - WAIT_BYTE, on rx_done: shift_reg={shift_reg[LEN-LEN_DATA-1:0],byte}; timer=0; byte_idx++.
//   On the LEN/LEN_DATA-th byte -> WRITE.
// - WAIT_BYTE, no rx_done: timer++; when timer reaches TIMEOUT_CYCLES-1 -> ERROR. No partial word is written.
// - WRITE (exactly 1 cycle): mem_wr_en=1, mem_addr=addr, mem_wr_data=shift_reg. Next cycle: addr++, word_count++.
//   - word==HALT_WORD -> DONE (or CHECK with macro).
//   - else if addr==CANT_INSTRUCCIONES-1 -> ERROR (overflow; last word already written).
//   - else -> WAIT_BYTE with byte_idx=0.
// - rx_done outside WAIT_BYTE/CHECK is dropped (unreachable at UART rates).
// - A HALT word in the last slot ends in DONE, not ERROR.
// - mem_addr/mem_wr_data hold their last values when mem_wr_en=0.
// - DONE/ERROR are sticky until next start or reset. Reset mid-load aborts immediately; no further writes.
// CONFIGURATION
// - PROGRAM_CHECKSUM_EN defined:
//   - running XOR of every data byte (incl. HALT bytes); after HALT write -> CHECK.
//   - CHECK waits for one byte; timeout applies; byte==XOR -> DONE, else ERROR.
// - PROGRAM_CHECKSUM_EN undefined:
//   - no CHECK state, no XOR register; HALT write -> DONE directly.
//   - a trailing extra byte is ignored.
// TESTING
// - Basic load: start, bytes 00 00 00 01 FF FF FF FF -> writes @0=0x00000001, @1=0xFFFFFFFF; done=1; word_count=2; hold_mips 1->0.
// - Timeout (TIMEOUT_CYCLES=100): start, 2 bytes, silence -> error=1 at 100 cycles after last byte; no mem_wr_en; hold_mips stays 1.
// - Overflow (CANT_INSTRUCCIONES=4): 4 non-HALT words -> 4 writes @0..3, error=1, word_count=4; 4 HALT words -> done=1.
// - Control: start while busy ignored (addr keeps counting); reset low mid-word -> all outputs 0 async; new start reloads from @0.
// - Checksum (macro on): 12 34 56 78 FF FF FF FF then 0x08 -> done; 0x09 -> error. Macro off: same stream -> done before the 0x08 byte; 0x08 ignored.

Source files
------------

// File: rtl/program_loader.sv
// Loads a program byte-by-byte from the UART receiver into instruction memory, holding the core in reset meanwhile.
// Optional feature macro: PROGRAM_CHECKSUM_EN (a trailing XOR checksum byte is verified after the HALT word).
module program_loader #(
  parameter int              LEN                = 32,
  parameter int              LEN_DATA           = 8,
  parameter int              CANT_INSTRUCCIONES = 64,
  parameter int              NB_ADDR            = $clog2(CANT_INSTRUCCIONES),
  parameter logic [LEN-1:0]  HALT_WORD          = 32'hFFFFFFFF,
  parameter int              TIMEOUT_CYCLES     = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                rx_done,
  input  logic [LEN_DATA-1:0] uart_data_in,
  output logic                mem_wr_en,
  output logic [NB_ADDR-1:0]  mem_addr,
  output logic [LEN-1:0]      mem_wr_data,
  output logic                hold_mips,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [NB_ADDR:0]    word_count
);

  localparam int BYTES = LEN / LEN_DATA;
  localparam int IDX_W = $clog2(BYTES) + 1;
  localparam int TIM_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int WC_W  = NB_ADDR + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_BYTE,
    S_WRITE,
`ifdef PROGRAM_CHECKSUM_EN
    S_CHECK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [NB_ADDR-1:0]  addr_q, addr_d;
  logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
  logic [TIM_W-1:0]    timer_q, timer_d;
  logic [LEN-1:0]      shift_q, shift_d;
  logic [WC_W-1:0]     word_count_q, word_count_d;
  logic                mem_wr_en_q, mem_wr_en_d;
  logic [NB_ADDR-1:0]  mem_addr_q, mem_addr_d;
  logic [LEN-1:0]      mem_wr_data_q, mem_wr_data_d;
  logic                busy_q, busy_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
`ifdef PROGRAM_CHECKSUM_EN
  logic [LEN_DATA-1:0] xor_q, xor_d;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    byte_idx_d    = byte_idx_q;
    timer_d       = timer_q;
    shift_d       = shift_q;
    word_count_d  = word_count_q;
    mem_wr_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
`ifdef PROGRAM_CHECKSUM_EN
    xor_d         = xor_q;
`endif
    case (state_q)
      S_WAIT_BYTE: begin
        if (rx_done) begin
          shift_d = {shift_q[LEN-LEN_DATA-1:0], uart_data_in};
          timer_d = '0;
`ifdef PROGRAM_CHECKSUM_EN
          xor_d   = xor_q ^ uart_data_in;
`endif
          if (byte_idx_q == IDX_W'(BYTES - 1)) begin
            // Word complete: present the write on the registered port during WRITE.
            state_d       = S_WRITE;
            byte_idx_d    = '0;
            mem_wr_en_d   = 1'b1;
            mem_addr_d    = addr_q;
            mem_wr_data_d = shift_d;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
          end
        end else if (timer_q == TIM_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + TIM_W'(1);
        end
      end
      S_WRITE: begin
        addr_d       = addr_q + NB_ADDR'(1);
        word_count_d = word_count_q + WC_W'(1);
        timer_d      = '0;
        byte_idx_d   = '0;
        if (shift_q == HALT_WORD) begin
`ifdef PROGRAM_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else if (addr_q == NB_ADDR'(CANT_INSTRUCCIONES - 1)) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_WAIT_BYTE;
        end
      end
`ifdef PROGRAM_CHECKSUM_EN
      S_CHECK: begin
        if (rx_done) begin
          state_d = (uart_data_in == xor_q) ? S_DONE : S_ERROR;
        end else if (timer_q == TIM_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_ERROR;
        end else begin
          timer_d = timer_q + TIM_W'(1);
        end
      end
`endif
      default: begin
        // IDLE, DONE and ERROR all accept a new load request.
        if (start) begin
          state_d      = S_WAIT_BYTE;
          addr_d       = '0;
          byte_idx_d   = '0;
          word_count_d = '0;
          timer_d      = '0;
`ifdef PROGRAM_CHECKSUM_EN
          xor_d        = '0;
`endif
        end
      end
    endcase

    busy_d  = (state_d == S_WAIT_BYTE) || (state_d == S_WRITE)
`ifdef PROGRAM_CHECKSUM_EN
              || (state_d == S_CHECK)
`endif
              ;
    hold_d  = busy_d || (state_d == S_ERROR);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      byte_idx_q    <= '0;
      timer_q       <= '0;
      shift_q       <= '0;
      word_count_q  <= '0;
      mem_wr_en_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      busy_q        <= 1'b0;
      hold_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
`ifdef PROGRAM_CHECKSUM_EN
      xor_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      byte_idx_q    <= byte_idx_d;
      timer_q       <= timer_d;
      shift_q       <= shift_d;
      word_count_q  <= word_count_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      busy_q        <= busy_d;
      hold_q        <= hold_d;
      done_q        <= done_d;
      error_q       <= error_d;
`ifdef PROGRAM_CHECKSUM_EN
      xor_q         <= xor_d;
`endif
    end
  end

  assign mem_wr_en   = mem_wr_en_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign hold_mips   = hold_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (4-word memory, 100-cycle timeout); memory writes are scored against an expected queue.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        rx_done;
  logic [7:0]  uart_data_in;
  logic        mem_wr_en;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wr_data;
  logic        hold_mips;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  word_count;

  int          total = 0;
  int          bad   = 0;
  int          wr_cnt = 0;
  int          wr_snap;
  logic [33:0] exp_q[$];
  logic [7:0]  sum_x;

  program_loader #(
    .LEN(32), .LEN_DATA(8), .CANT_INSTRUCCIONES(4),
    .HALT_WORD(32'hFFFFFFFF), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .rx_done(rx_done),
    .uart_data_in(uart_data_in), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .hold_mips(hold_mips), .busy(busy),
    .done(done), .error(error), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe pops one expected {addr,data} entry.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      wr_cnt++;
      check("wr_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e[33:32]));
        check("wr_data", 64'(mem_wr_data), 64'(e[31:0]));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_done = 1'b1;
    uart_data_in = b;
    sum_x = sum_x ^ b;
    @(negedge clk);
    rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [1:0] a);
    exp_q.push_back({a, w});
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], int'($urandom_range(0, 2)));
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sum_x = 8'h00;
  endtask

  task automatic finish_cs();
`ifdef PROGRAM_CHECKSUM_EN
    send_byte(sum_x, 0);
`endif
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", 64'(done | error), 64'd1);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; rx_done = 1'b0; uart_data_in = 8'h00; sum_x = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hold", 64'(hold_mips), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_wr_en", 64'(mem_wr_en), 64'd0);
    check("rst_wcount", 64'(word_count), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wr_data), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic load
    do_start();
    check("basic_busy", 64'(busy), 64'd1);
    check("basic_hold_on", 64'(hold_mips), 64'd1);
    send_word(32'h00000001, 2'd0);
    send_word(32'hFFFFFFFF, 2'd1);
    finish_cs();
    wait_end(50);
    check("basic_done", 64'(done), 64'd1);
    check("basic_error", 64'(error), 64'd0);
    check("basic_wcount", 64'(word_count), 64'd2);
    check("basic_hold_off", 64'(hold_mips), 64'd0);
    check("basic_busy_off", 64'(busy), 64'd0);
    check("basic_addr_hold", 64'(mem_addr), 64'd1);
    check("basic_data_hold", 64'(mem_wr_data), 64'hFFFFFFFF);
    check("basic_q_empty", 64'(exp_q.size()), 64'd0);

    // Overflow: four non-HALT words fill the memory
    do_start();
    for (int i = 0; i < 4; i++) send_word($urandom() & 32'h7FFFFFFF, 2'(i));
    wait_end(50);
    check("ovf_error", 64'(error), 64'd1);
    check("ovf_done", 64'(done), 64'd0);
    check("ovf_wcount", 64'(word_count), 64'd4);
    check("ovf_hold", 64'(hold_mips), 64'd1);
    check("ovf_busy", 64'(busy), 64'd0);
    check("ovf_q_empty", 64'(exp_q.size()), 64'd0);

    // HALT in the last slot ends in DONE
    do_start();
    for (int i = 0; i < 3; i++) send_word($urandom() & 32'h7FFFFFFF, 2'(i));
    send_word(32'hFFFFFFFF, 2'd3);
    finish_cs();
    wait_end(50);
    check("lastslot_done", 64'(done), 64'd1);
    check("lastslot_error", 64'(error), 64'd0);
    check("lastslot_wcount", 64'(word_count), 64'd4);

    // Timeout after two bytes
    wr_snap = wr_cnt;
    do_start();
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    repeat (99) @(negedge clk);
    check("tmo_not_yet", 64'(error), 64'd0);
    check("tmo_busy_before", 64'(busy), 64'd1);
    @(negedge clk);
    check("tmo_error", 64'(error), 64'd1);
    check("tmo_hold", 64'(hold_mips), 64'd1);
    check("tmo_wcount", 64'(word_count), 64'd0);
    check("tmo_no_write", 64'(wr_cnt - wr_snap), 64'd0);

    // start while busy is ignored
    do_start();
    send_word(32'hA5A5_0001, 2'd0);
    exp_q.push_back({2'd1, 32'h1234_5678});
    send_byte(8'h12, 0);
    send_byte(8'h34, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sib_busy", 64'(busy), 64'd1);
    send_byte(8'h56, 1);
    send_byte(8'h78, 0);
    @(negedge clk);
    send_word(32'hFFFFFFFF, 2'd2);
    finish_cs();
    wait_end(50);
    check("sib_done", 64'(done), 64'd1);
    check("sib_wcount", 64'(word_count), 64'd3);
    check("sib_q_empty", 64'(exp_q.size()), 64'd0);

    // Reset mid-word, then reload from address 0
    do_start();
    send_word(32'h0BAD_F00D, 2'd0);
    send_byte(8'hC0, 0);
    send_byte(8'hDE, 0);
    wr_snap = wr_cnt;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_hold", 64'(hold_mips), 64'd0);
    check("mid_rst_wcount", 64'(word_count), 64'd0);
    check("mid_rst_addr", 64'(mem_addr), 64'd0);
    check("mid_rst_wdata", 64'(mem_wr_data), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_no_write", 64'(wr_cnt - wr_snap), 64'd0);
    do_start();
    send_word(32'hC0DE_0042, 2'd0);
    send_word(32'hFFFFFFFF, 2'd1);
    finish_cs();
    wait_end(50);
    check("reload_done", 64'(done), 64'd1);
    check("reload_wcount", 64'(word_count), 64'd2);

    // Checksum stream 12 34 56 78 FF FF FF FF + trailing byte
    do_start();
    send_word(32'h12345678, 2'd0);
    send_word(32'hFFFFFFFF, 2'd1);
`ifdef PROGRAM_CHECKSUM_EN
    check("cs_wait_busy", 64'(busy), 64'd1);
    send_byte(8'h08, 0);
    wait_end(50);
    check("cs_good_done", 64'(done), 64'd1);
    check("cs_good_error", 64'(error), 64'd0);
    do_start();
    send_word(32'h12345678, 2'd0);
    send_word(32'hFFFFFFFF, 2'd1);
    send_byte(8'h09, 0);
    wait_end(50);
    check("cs_bad_error", 64'(error), 64'd1);
    check("cs_bad_done", 64'(done), 64'd0);
`else
    wait_end(50);
    check("cs_off_done", 64'(done), 64'd1);
    wr_snap = wr_cnt;
    send_byte(8'h08, 0);
    repeat (3) @(negedge clk);
    check("cs_off_still_done", 64'(done), 64'd1);
    check("cs_off_busy", 64'(busy), 64'd0);
    check("cs_off_wcount", 64'(word_count), 64'd2);
    check("cs_off_no_write", 64'(wr_cnt - wr_snap), 64'd0);
`endif
    check("final_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
